// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_ctrl
// Purpose  : Frame sequencer for the KERNELxKERNEL sliding-window front end of
//            the LeNet-5 conv layers. Accepts a raster pixel stream
//            (valid/ready), drives the line-buffer shift enable, tracks x/y,
//            flags valid window positions, then waits PIPE_LAT cycles for the
//            conv pipeline to drain before pulsing frame_done.
// Ports    : clk, rst_n (async, active low)
//            start_i        - frame start pulse, honoured only in IDLE
//            pix_valid_i    - upstream pixel valid
//            pix_ready_o    - controller accepts a pixel (RUN & conv_ready_i)
//            conv_ready_i   - conv engine can take a window this cycle
//            lb_shift_o     - line buffer shift enable (valid & ready)
//            win_valid_o    - registered, window at line-buffer output is valid
//            win_x_o/win_y_o- coordinates of the pixel that completed it
//            busy_o         - high in every state except IDLE
//            frame_done_o   - one-cycle pulse on FLUSH->IDLE
//            stall_cycles_o - (optional) RUN cycles with valid & !conv_ready
// Options  : CONV_WINDOW_CTRL_STALL_CNT_EN adds the stall_cycles_o counter.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_ctrl #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int KERNEL     = 5,
    parameter int PIPE_LAT   = 4,
    parameter int CW         = $clog2(IMG_WIDTH),
    parameter int CH         = $clog2(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          pix_valid_i,
    output logic          pix_ready_o,
    input  logic          conv_ready_i,
    output logic          lb_shift_o,
    output logic          win_valid_o,
    output logic [CW-1:0] win_x_o,
    output logic [CH-1:0] win_y_o,
    output logic          busy_o,
    output logic          frame_done_o
`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cycles_o
`endif
);

    // Flush counter needs at least one bit even for PIPE_LAT == 1.
    localparam int            FW           = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CW-1:0] C_X_LAST     = CW'(IMG_WIDTH - 1);
    localparam logic [CH-1:0] C_Y_LAST     = CH'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] C_WIN_MIN_X  = CW'(KERNEL - 1);
    localparam logic [CH-1:0] C_WIN_MIN_Y  = CH'(KERNEL - 1);
    localparam logic [FW-1:0] C_FLUSH_LAST = FW'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] x_cnt_q, x_cnt_d;
    logic [CH-1:0] y_cnt_q, y_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic          win_valid_q;
    logic [CW-1:0] win_x_q;
    logic [CH-1:0] win_y_q;

    logic          w_shift;
    logic          w_win_hit;

    assign pix_ready_o = (state_q == ST_RUN) && conv_ready_i;
    assign w_shift     = pix_valid_i && pix_ready_o;
    assign lb_shift_o  = w_shift;
    assign busy_o      = (state_q != ST_IDLE);

    // x rule alone suppresses windows that would straddle a row wrap.
    assign w_win_hit   = (x_cnt_q >= C_WIN_MIN_X) && (y_cnt_q >= C_WIN_MIN_Y);

    always_comb begin
        state_d      = state_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        frame_done_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    x_cnt_d = '0;
                    y_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (w_shift) begin
                    if (x_cnt_q == C_X_LAST) begin
                        x_cnt_d = '0;
                        if (y_cnt_q == C_Y_LAST) begin
                            y_cnt_d     = '0;
                            flush_cnt_d = '0;
                            state_d     = ST_FLUSH;
                        end else begin
                            y_cnt_d = y_cnt_q + CH'(1);
                        end
                    end else begin
                        x_cnt_d = x_cnt_q + CW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == C_FLUSH_LAST) begin
                    state_d      = ST_IDLE;
                    flush_cnt_d  = '0;
                    frame_done_o = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Window flag lines up with the 1-cycle registered line-buffer output;
    // coordinates hold between shifts, the flag does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q <= 1'b0;
            win_x_q     <= '0;
            win_y_q     <= '0;
        end else if (w_shift) begin
            win_valid_q <= w_win_hit;
            win_x_q     <= x_cnt_q;
            win_y_q     <= y_cnt_q;
        end else begin
            win_valid_q <= 1'b0;
        end
    end

    assign win_valid_o = win_valid_q;
    assign win_x_o     = win_x_q;
    assign win_y_o     = win_y_q;

`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && start_i) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_RUN) && pix_valid_i && !conv_ready_i
                     && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_ctrl
// Purpose  : Self-checking bench for conv_window_ctrl. Frame scenarios come
//            from a vector table; expected windows are derived from the
//            bench's own raster index and queued on every accepted pixel,
//            then popped and compared one cycle later. Hand-written sequences
//            cover reset, mid-frame abort and the optional stall counter
//            (CONV_WINDOW_CTRL_STALL_CNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_ctrl;

    localparam int W  = 32;
    localparam int H  = 32;
    localparam int K  = 5;
    localparam int PL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pix_valid = 1'b0;
    logic       conv_ready = 1'b0;
    logic       pix_ready, lb_shift, win_valid, busy, frame_done;
    logic [4:0] win_x, win_y;
`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    conv_window_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .KERNEL    (K),
        .PIPE_LAT  (PL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .pix_valid_i   (pix_valid),
        .pix_ready_o   (pix_ready),
        .conv_ready_i  (conv_ready),
        .lb_shift_o    (lb_shift),
        .win_valid_o   (win_valid),
        .win_x_o       (win_x),
        .win_y_o       (win_y),
        .busy_o        (busy),
        .frame_done_o  (frame_done)
`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
        ,
        .stall_cycles_o(stall_cycles)
`endif
    );

    typedef struct {
        bit v;
        int x;
        int y;
    } exp_t;

    typedef struct {
        int rdy_pct;
        int vld_pct;
        int extra_start;   // raster index at which to pulse start, -1 = none
        bit flush_start;   // pulse start right after the last pixel
        int exp_shifts;
        int exp_wins;
        int exp_dones;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   fidx = 0;
    int   shifts = 0, wins = 0, dones = 0, lowx = 0;
    int   last_shift_cyc = 0, done_cyc = 0;
    int   fx = 0, fy = 0, lx = 0, ly = 0;
    bit   first_seen = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock: sample/check at negedge, then advance to just after posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            fidx = 0;
        end else begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("win_valid", int'(win_valid), int'(e.v));
                if (e.v && win_valid) begin
                    chk("win_x", int'(win_x), e.x);
                    chk("win_y", int'(win_y), e.y);
                end
            end else begin
                chk("win_valid_no_shift", int'(win_valid), 0);
            end
            if (win_valid) begin
                wins++;
                if (win_x < 5'(K - 1)) lowx++;
                if (!first_seen) begin
                    fx = int'(win_x);
                    fy = int'(win_y);
                    first_seen = 1;
                end
                lx = int'(win_x);
                ly = int'(win_y);
            end
            if (lb_shift) chk("shift_needs_ready", int'(conv_ready && pix_valid), 1);
            if (!busy) chk("ready_when_idle", int'(pix_ready), 0);
            if (start && !busy) fidx = 0;
            if (lb_shift) begin
                e.x = fidx % W;
                e.y = fidx / W;
                e.v = (e.x >= K - 1) && (e.y >= K - 1);
                sb.push_back(e);
                fidx++;
                shifts++;
                last_shift_cyc = cyc;
            end
            if (frame_done) begin
                dones++;
                done_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_rand(input vec_t v);
        pix_valid  = ($urandom_range(0, 99) < v.vld_pct);
        conv_ready = ($urandom_range(0, 99) < v.rdy_pct);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_pix_ready"},  int'(pix_ready),  0);
        chk({tag, "_lb_shift"},   int'(lb_shift),   0);
        chk({tag, "_win_valid"},  int'(win_valid),  0);
        chk({tag, "_win_x"},      int'(win_x),      0);
        chk({tag, "_win_y"},      int'(win_y),      0);
        chk({tag, "_busy"},       int'(busy),       0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    task automatic run_frame(input vec_t v);
        int s0, w0, d0, l0, n;
        bit sp, fp;
        s0 = shifts; w0 = wins; d0 = dones; l0 = lowx;
        first_seen = 0; sp = 0; fp = 0; n = 0;
        drive_rand(v);
        start = 1'b1;
        step();
        start = 1'b0;
        while (dones == d0 && n < 20000) begin
            drive_rand(v);
            start = 1'b0;
            if (v.extra_start >= 0 && !sp && fidx == v.extra_start) begin
                start = 1'b1;
                sp = 1;
            end
            if (v.flush_start && !fp && fidx == W * H) begin
                start = 1'b1;
                fp = 1;
            end
            step();
            n++;
        end
        start = 1'b0;
        repeat (6) begin
            drive_rand(v);
            step();
        end
        chk("frame_shifts",     shifts - s0, v.exp_shifts);
        chk("frame_windows",    wins - w0,   v.exp_wins);
        chk("frame_done_count", dones - d0,  v.exp_dones);
        chk("windows_x_lt_k",   lowx - l0,   0);
        chk("first_win_x", fx, K - 1);
        chk("first_win_y", fy, K - 1);
        chk("last_win_x",  lx, W - 1);
        chk("last_win_y",  ly, H - 1);
        chk("done_latency", done_cyc - last_shift_cyc, PL);
        chk("busy_after_frame", int'(busy), 0);
    endtask

    vec_t tbl[3];

    initial begin
        int n;
        tbl[0] = '{rdy_pct: 100, vld_pct: 100, extra_start: -1,  flush_start: 0,
                   exp_shifts: W * H, exp_wins: (W - K + 1) * (H - K + 1), exp_dones: 1};
        tbl[1] = '{rdy_pct: 50,  vld_pct: 70,  extra_start: -1,  flush_start: 0,
                   exp_shifts: W * H, exp_wins: (W - K + 1) * (H - K + 1), exp_dones: 1};
        tbl[2] = '{rdy_pct: 100, vld_pct: 100, extra_start: 100, flush_start: 1,
                   exp_shifts: W * H, exp_wins: (W - K + 1) * (H - K + 1), exp_dones: 1};

        // Reset: held low for 3 cycles with inputs asserted.
        rst_n = 1'b0;
        pix_valid = 1'b1;
        conv_ready = 1'b1;
        repeat (3) step();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 3; i++) run_frame(tbl[i]);

        // Mid-frame asynchronous reset at pixel 500.
        pix_valid = 1'b1;
        conv_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (fidx < 500 && n < 5000) begin
            step();
            n++;
        end
        chk("reached_pixel_500", int'(fidx >= 500), 1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("abort");
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("abort_stays_idle", int'(busy), 0);
        run_frame(tbl[0]);

`ifdef CONV_WINDOW_CTRL_STALL_CNT_EN
        // 37 stalled RUN cycles with valid held high.
        begin
            int d0;
            d0 = dones;
            pix_valid = 1'b1;
            conv_ready = 1'b1;
            start = 1'b1;
            step();
            start = 1'b0;
            n = 0;
            while (fidx < 200 && n < 5000) begin
                step();
                n++;
            end
            conv_ready = 1'b0;
            repeat (37) step();
            conv_ready = 1'b1;
            n = 0;
            while (dones == d0 && n < 5000) begin
                step();
                n++;
            end
            chk("stall_frame_done", dones - d0, 1);
            chk("stall_cycles_at_done", int'(stall_cycles), 37);
            start = 1'b1;
            step();
            start = 1'b0;
            chk("stall_cycles_cleared", int'(stall_cycles), 0);
            d0 = dones;
            n = 0;
            while (dones == d0 && n < 5000) begin
                step();
                n++;
            end
            chk("stall_clear_frame_done", dones - d0, 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
